pipeline_stall_ctrl: RTL and testbench

//  Sequences stalls and flushes for the 5-stage MIPS pipeline. Consumes the
//  raw hazard request from the hazard detector, plus branch/jump resolution.

---
 rtl/pipe_ctrl_pkg.sv | 34 +++
 rtl/pipe_perf_counter.sv | 30 +++
 rtl/pipeline_stall_ctrl.sv | 151 +++++++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// pipe_ctrl_pkg
//   Shared types and constants for the 5-stage pipeline stall/flush sequencer.
//   - state_t           : sequencer state encoding (RUN=0, STALL=1)
//   - REMAIN_W          : width of the remaining-bubble counter and of the
//                         hazard bubble request
//   - MAX_STALL_DEFAULT : default upper bound on bubbles per hazard
//   - bubble_count()    : turns a raw bubble request into the effective count
// ----------------------------------------------------------------------------
package pipe_ctrl_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    localparam int REMAIN_W          = 3;
    localparam int MAX_STALL_DEFAULT = 3;

    // A request of 0 bubbles still stalls for one cycle; anything above the
    // configured maximum is clamped to it.
    function automatic logic [REMAIN_W-1:0] bubble_count(
        input logic [REMAIN_W-1:0] req,
        input logic [REMAIN_W-1:0] max_n
    );
        logic [REMAIN_W-1:0] n;
        n = (req == '0) ? REMAIN_W'(1) : req;
        if (n > max_n) begin
            n = max_n;
        end
        return n;
    endfunction

endpackage

// File: rtl/pipe_perf_counter.sv
// ----------------------------------------------------------------------------
// pipe_perf_counter
//   Saturating event counter: counts up by one on every clock with inc high
//   and holds at all-ones once it gets there.
// Ports:
//   clk   in  1      counting clock
//   rst   in  1      asynchronous, active-high clear
//   inc   in  1      count this cycle
//   count out CNT_W  current count
// ----------------------------------------------------------------------------
module pipe_perf_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples values from before the edge, independent of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// ----------------------------------------------------------------------------
// pipeline_stall_ctrl
//   Stall / flush sequencer for the 5-stage MIPS pipeline. Takes the raw
//   hazard request (with a bubble count) and branch/jump resolution, and
//   drives the PC and IF_ID write enables plus the per-stage flush controls.
//   Priority, highest first: BranchTaken > stall > JumpTaken > normal.
//
// Configuration macro:
//   PIPE_PERF_CNT_EN  when defined, StallCount/FlushCount are saturating
//                     performance counters; otherwise they are tied to 0 and
//                     no counter flops exist.
//
// Ports:
//   Clk           in   1      pipeline clock, rising edge
//   Reset         in   1      asynchronous, active-high reset
//   HazardReq     in   1      stall the instruction in IF/ID
//   HazardCycles  in   3      bubbles requested with HazardReq (0 means 1)
//   BranchTaken   in   1      branch in EX_MEM resolved taken
//   JumpTaken     in   1      jump decoded in ID
//   PCWrite       out  1      PC loads next PC
//   IF_ID_Write   out  1      IF_ID register captures
//   IF_ID_Flush   out  1      IF_ID loads a nop
//   ID_EX_Flush   out  1      ID_EX control zeroed (bubble)
//   EX_MEM_Flush  out  1      EX_MEM control zeroed
//   Busy          out  1      multi-cycle stall in progress (state STALL)
//   StallCount    out  CNT_W  cycles with PCWrite=0
//   FlushCount    out  CNT_W  branch/jump redirects acted on
// ----------------------------------------------------------------------------
module pipeline_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MAX_STALL = MAX_STALL_DEFAULT,
    parameter int CNT_W     = 32
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                HazardReq,
    input  logic [REMAIN_W-1:0] HazardCycles,
    input  logic                BranchTaken,
    input  logic                JumpTaken,
    output logic                PCWrite,
    output logic                IF_ID_Write,
    output logic                IF_ID_Flush,
    output logic                ID_EX_Flush,
    output logic                EX_MEM_Flush,
    output logic                Busy,
    output logic [CNT_W-1:0]    StallCount,
    output logic [CNT_W-1:0]    FlushCount
);

    localparam logic [REMAIN_W-1:0] MAX_N = REMAIN_W'(MAX_STALL);

    state_t              state_q, state_d;
    logic [REMAIN_W-1:0] remain_q, remain_d;
    logic [REMAIN_W-1:0] req_n;

    assign req_n = bubble_count(HazardCycles, MAX_N);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= RUN;
            remain_q <= '0;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
        end
    end

    // The first bubble of a hazard is issued from RUN in the same cycle the
    // request arrives; STALL then covers the remaining N-1 bubbles, with
    // remain_q counting the bubbles still owed including the current one.
    always_comb begin
        // NOTE: every output and next-state value gets a default first so no
        // path through the branches below can infer a latch.
        state_d      = state_q;
        remain_d     = remain_q;
        PCWrite      = 1'b1;
        IF_ID_Write  = 1'b1;
        IF_ID_Flush  = 1'b0;
        ID_EX_Flush  = 1'b0;
        EX_MEM_Flush = 1'b0;
        Busy         = 1'b0;

        if (Reset) begin
            PCWrite      = 1'b0;
            IF_ID_Write  = 1'b0;
            IF_ID_Flush  = 1'b1;
            ID_EX_Flush  = 1'b1;
            EX_MEM_Flush = 1'b1;
            state_d      = RUN;
            remain_d     = '0;
        end else if (BranchTaken) begin
            // Taken branch squashes everything younger and aborts any stall.
            IF_ID_Flush  = 1'b1;
            ID_EX_Flush  = 1'b1;
            EX_MEM_Flush = 1'b1;
            Busy         = (state_q == STALL);
            state_d      = RUN;
            remain_d     = '0;
        end else if (state_q == STALL) begin
            PCWrite     = 1'b0;
            IF_ID_Write = 1'b0;
            ID_EX_Flush = 1'b1;
            Busy        = 1'b1;
            remain_d    = remain_q - REMAIN_W'(1);
            if (remain_q <= REMAIN_W'(1)) begin
                state_d  = RUN;
                remain_d = '0;
            end
        end else if (HazardReq) begin
            // A coincident jump is dropped here; ID re-presents it afterwards.
            PCWrite     = 1'b0;
            IF_ID_Write = 1'b0;
            ID_EX_Flush = 1'b1;
            if (req_n > REMAIN_W'(1)) begin
                state_d  = STALL;
                remain_d = req_n - REMAIN_W'(1);
            end
        end else if (JumpTaken) begin
            IF_ID_Flush = 1'b1;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic stall_inc;
    logic flush_inc;

    // PCWrite together with IF_ID_Flush occurs only for an honoured branch or
    // jump; PCWrite is already 0 throughout reset.
    assign stall_inc = !Reset && !PCWrite;
    assign flush_inc = PCWrite && IF_ID_Flush;

    pipe_perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (Clk),
        .rst   (Reset),
        .inc   (stall_inc),
        .count (StallCount)
    );

    pipe_perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (Clk),
        .rst   (Reset),
        .inc   (flush_inc),
        .count (FlushCount)
    );
`else
    assign StallCount = '0;
    assign FlushCount = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pipeline_stall_ctrl
//   Directed stimulus for pipeline_stall_ctrl. A bubble-debt model (how many
//   bubbles are still owed) predicts every control output and the counters;
//   it is compared on each falling edge. Hand-computed literal expectations
//   in the stimulus pin the key scenarios. Honours PIPE_PERF_CNT_EN.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pipeline_stall_ctrl;

    localparam int MAX_STALL = 3;
    localparam int CNT_W     = 32;

    logic             Clk = 1'b0;
    logic             Reset;
    logic             HazardReq;
    logic [2:0]       HazardCycles;
    logic             BranchTaken;
    logic             JumpTaken;
    logic             PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, Busy;
    logic [CNT_W-1:0] StallCount, FlushCount;

    int vectors     = 0;
    int miscompares = 0;

    always #5 Clk = ~Clk;

    pipeline_stall_ctrl #(.MAX_STALL(MAX_STALL), .CNT_W(CNT_W)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .HazardReq    (HazardReq),
        .HazardCycles (HazardCycles),
        .BranchTaken  (BranchTaken),
        .JumpTaken    (JumpTaken),
        .PCWrite      (PCWrite),
        .IF_ID_Write  (IF_ID_Write),
        .IF_ID_Flush  (IF_ID_Flush),
        .ID_EX_Flush  (ID_EX_Flush),
        .EX_MEM_Flush (EX_MEM_Flush),
        .Busy         (Busy),
        .StallCount   (StallCount),
        .FlushCount   (FlushCount)
    );

    // {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, Busy}
    logic [5:0] ctrl;
    assign ctrl = {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, Busy};

`ifdef PIPE_PERF_CNT_EN
    // Narrow-counter copy to exercise saturation at all-ones.
    logic       s_pcw, s_ifw, s_iff, s_idf, s_exf, s_busy;
    logic [1:0] s_stall, s_flush;
    pipeline_stall_ctrl #(.MAX_STALL(MAX_STALL), .CNT_W(2)) dut_sat (
        .Clk          (Clk),
        .Reset        (Reset),
        .HazardReq    (HazardReq),
        .HazardCycles (HazardCycles),
        .BranchTaken  (BranchTaken),
        .JumpTaken    (JumpTaken),
        .PCWrite      (s_pcw),
        .IF_ID_Write  (s_ifw),
        .IF_ID_Flush  (s_iff),
        .ID_EX_Flush  (s_idf),
        .EX_MEM_Flush (s_exf),
        .Busy         (s_busy),
        .StallCount   (s_stall),
        .FlushCount   (s_flush)
    );
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int     owed     = 0;   // bubbles still to be issued after this cycle's
    longint m_stalls = 0;
    longint m_flush  = 0;
    int     nxt_owed;
    longint nxt_stalls, nxt_flush;

    function automatic longint sat(input longint v, input int w);
        longint top;
        top = (longint'(1) << w) - 1;
        return (v > top) ? top : v;
    endfunction

    always @(negedge Clk) begin
        logic [5:0] exp_ctrl;
        int         n;
        nxt_owed   = owed;
        nxt_stalls = m_stalls;
        nxt_flush  = m_flush;
        if (Reset) begin
            exp_ctrl = 6'b001110;
            nxt_owed = 0;
        end else if (BranchTaken) begin
            exp_ctrl  = {5'b11111, owed > 0};
            nxt_owed  = 0;
            nxt_flush = m_flush + 1;
        end else if (owed > 0) begin
            exp_ctrl   = 6'b000101;
            nxt_owed   = owed - 1;
            nxt_stalls = m_stalls + 1;
        end else if (HazardReq) begin
            n = (HazardCycles == 0) ? 1 : int'(HazardCycles);
            if (n > MAX_STALL) n = MAX_STALL;
            exp_ctrl   = 6'b000100;
            nxt_owed   = n - 1;
            nxt_stalls = m_stalls + 1;
        end else if (JumpTaken) begin
            exp_ctrl  = 6'b111000;
            nxt_flush = m_flush + 1;
        end else begin
            exp_ctrl = 6'b110000;
        end
        check("ctrl_model", 32'(ctrl), 32'(exp_ctrl));
`ifdef PIPE_PERF_CNT_EN
        check("stall_cnt_model", StallCount, 32'(sat(m_stalls, CNT_W)));
        check("flush_cnt_model", FlushCount, 32'(sat(m_flush, CNT_W)));
        check("stall_cnt_sat_model", 32'(s_stall), 32'(sat(m_stalls, 2)));
        check("flush_cnt_sat_model", 32'(s_flush), 32'(sat(m_flush, 2)));
`else
        check("stall_cnt_off", StallCount, 32'd0);
        check("flush_cnt_off", FlushCount, 32'd0);
`endif
    end

    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            owed     <= 0;
            m_stalls <= 0;
            m_flush  <= 0;
        end else begin
            owed     <= nxt_owed;
            m_stalls <= nxt_stalls;
            m_flush  <= nxt_flush;
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic h, input logic [2:0] hc, input logic b, input logic j);
        HazardReq    = h;
        HazardCycles = hc;
        BranchTaken  = b;
        JumpTaken    = j;
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Reset = 1'b0;
        drive(0, 0, 0, 0);
        #1 Reset = 1'b1;
        #1 check("reset_async_outputs", 32'(ctrl), 32'b001110);
        step(); step();
        Reset = 1'b0;
        #1 check("run_after_reset", 32'(ctrl), 32'b110000);

        // Single-cycle hazard: one bubble, never Busy.
        step(); drive(1, 1, 0, 0);
        #1 check("t2_bubble", 32'(ctrl), 32'b000100);
        step(); drive(0, 0, 0, 0);
        #1 check("t2_resume", 32'(ctrl), 32'b110000);

        // Zero-cycle request behaves as one bubble.
        step(); drive(1, 0, 0, 0);
        #1 check("hc0_bubble", 32'(ctrl), 32'b000100);
        step(); drive(0, 0, 0, 0);
        #1 check("hc0_resume", 32'(ctrl), 32'b110000);

        // Three bubbles; HazardReq held during STALL is ignored.
        step(); drive(1, 3, 0, 0);
        #1 check("t3_c1", 32'(ctrl), 32'b000100);
        step();
        #1 check("t3_c2", 32'(ctrl), 32'b000101);
        step(); drive(0, 0, 0, 0);
        #1 check("t3_c3", 32'(ctrl), 32'b000101);
        step();
        #1 check("t3_c4_run", 32'(ctrl), 32'b110000);

        // Branch on stall cycle 2 of 3 aborts the stall.
        step(); drive(1, 3, 0, 0);
        #1 check("t4_c1", 32'(ctrl), 32'b000100);
        step(); drive(0, 0, 1, 0);
        #1 check("t4_branch", 32'(ctrl), 32'b111111);
        step(); drive(0, 0, 0, 0);
        #1 check("t4_run", 32'(ctrl), 32'b110000);

        // Jump coincident with a stall is dropped, then honoured.
        step(); drive(1, 1, 0, 1);
        #1 check("t5_jump_dropped", 32'(ctrl), 32'b000100);
        step(); drive(0, 0, 0, 1);
        #1 check("t5_jump_taken", 32'(ctrl), 32'b111000);
        step(); drive(0, 0, 0, 0);

        // Request of 7 is clamped to MAX_STALL = 3.
        drive(1, 7, 0, 0);
        #1 check("clamp_c1", 32'(ctrl), 32'b000100);
        step(); drive(0, 0, 0, 0);
        #1 check("clamp_c2", 32'(ctrl), 32'b000101);
        step();
        #1 check("clamp_c3", 32'(ctrl), 32'b000101);
        step();
        #1 check("clamp_c4_run", 32'(ctrl), 32'b110000);

        // Asynchronous reset mid-stall discards the remaining bubbles.
        step(); drive(1, 3, 0, 0);
        step(); drive(0, 0, 0, 0);
        #2 Reset = 1'b1;
        #1 check("reset_mid_stall", 32'(ctrl), 32'b001110);
        step();
        Reset = 1'b0;
        #1 check("reset_discards_stall", 32'(ctrl), 32'b110000);

        // Counter scenario from a clean reset: 3 bubbles, then 2 bubbles
        // followed by a branch on the third cycle.
        step(); Reset = 1'b1;
        step(); Reset = 1'b0;
        drive(1, 3, 0, 0);
        step(); drive(0, 0, 0, 0);
        step();
        step(); drive(1, 3, 0, 0);
        step(); drive(0, 0, 0, 0);
        step(); drive(0, 0, 1, 0);
        step(); drive(0, 0, 0, 0);
        #1;
`ifdef PIPE_PERF_CNT_EN
        check("t6_stall_count", StallCount, 32'd5);
        check("t6_flush_count", FlushCount, 32'd1);
        check("t6_stall_saturated", 32'(s_stall), 32'd3);
        check("t6_flush_narrow", 32'(s_flush), 32'd1);
`else
        check("t6_stall_count_off", StallCount, 32'd0);
        check("t6_flush_count_off", FlushCount, 32'd0);
`endif
        step(); step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
